ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter data_width, default 32, RAM word width in bits.
REQ-002 Parameter addr_width, default 4, RAM address width in bits.
REQ-003 Parameter max_burst, default 4, maximum grants per locked ownership, legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqN  input  1  (N=0,1) requester N requests one access this cycle.
REQ-007 lockN  input  1  requester N asks to retain ownership after the current grant.
REQ-008 weN  input  1  1 = write, 0 = read.
REQ-009 addrN  input  addr_width  access address.
REQ-010 wdataN  input  data_width  write data.
REQ-011 gntN  output  1  access accepted this cycle (combinational).
REQ-012 rvalidN  output  1  registered; rdataN holds read data for N this cycle.
REQ-013 rdataN  output  data_width  equals ram_dout.
REQ-014 ram_read_address, ram_write_address  output  addr_width  to RAM.
REQ-015 ram_write  output  1  RAM write enable.
REQ-016 ram_din  output  data_width  RAM write data.
REQ-017 ram_dout  input  data_width  RAM registered read data, one-cycle latency.

Function
REQ-018 State machine SHALL have states IDLE, OWN0, OWN1, plus a burst counter cnt and a last-served pointer last.
REQ-019 IDLE: a single active req SHALL be granted; with both active, the requester != last SHALL be granted.
REQ-020 OWNx: only requester x SHALL be granted; the other requester's req SHALL be ignored.
REQ-021 A grant SHALL be combinational in the cycle req is high; the access completes in that cycle; requesters hold signals until gnt.
REQ-022 At most one gnt SHALL be high per cycle.
REQ-023 On every grant, last SHALL be set to the granted id.
REQ-024 IDLE grant to x with lockx=1 and max_burst>1 SHALL go to OWNx, cnt=1; otherwise stay IDLE.
REQ-025 OWNx grant SHALL increment cnt; go to IDLE if lockx=0 or the incremented cnt==max_burst, else remain OWNx.
REQ-026 OWNx with reqx=0 SHALL return to IDLE without a grant.
REQ-027 Granted cycle: ram_read_address=ram_write_address=addrx, ram_write=wex, ram_din=wdatax.
REQ-028 Cycle without grant: ram_write=0, addresses 0, ram_din 0.
REQ-029 Granted read (we=0) SHALL assert rvalidx exactly one cycle later, for one cycle; writes produce no rvalid.
REQ-030 Back-to-back reads SHALL yield back-to-back rvalid pulses, throughput one access per cycle.
REQ-031 max_burst=1 SHALL make lock inert; strict alternation under contention.

Reset
REQ-032 While reset is high: gnt0=gnt1=0, ram_write=0, rvalid0=rvalid1=0, and all requests are ignored.
REQ-033 After reset: state IDLE, cnt=0, last=1 (requester 0 wins first tie), rvalid registers 0.
REQ-034 Reset asserted mid-burst SHALL abandon ownership and drop any pending rvalid on the next edge.

Verification
REQ-035 After reset, req0=req1=1, we=0, lock=0, addr0=3, addr1=5 -> grants alternate 0,1,0,...; rvalid next cycle each time with mem[3]/mem[5].
REQ-036 req0 write addr 2 data 0xA5A5A5A5, next cycle read addr 2 -> gnt0 both cycles; rvalid0 on cycle 3 with rdata0=0xA5A5A5A5.
REQ-037 max_burst=4, lock0=1, req0 and req1 high continuously -> gnt0 for 4 cycles, then gnt1; req1 never granted during OWN0.
REQ-038 In OWN0, drop req0 for one cycle with req1 high -> no grant that cycle, IDLE; next cycle gnt1 (last=0).
REQ-039 Reset high in cycle 2 of an OWN1 burst with a read just granted -> no rvalid1 follows, IDLE, next tie goes to requester 0.
REQ-040 Throughout all scenarios the bench SHALL check gnt0&gnt1 never high together and ram_write=0 whenever no gnt is high.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port-style RAM
// with registered (one-cycle) read data.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   reqN, lockN, weN             requester N: access request, keep ownership, write
//   addrN, wdataN                requester N: address and write data
//   gntN                         combinational accept for requester N
//   rvalidN, rdataN              read return for requester N, one cycle after grant
//   ram_read_address,
//   ram_write_address, ram_write,
//   ram_din, ram_dout            RAM side; ram_dout has one-cycle read latency
//
// Arbitration: IDLE round-robins on ties using the last-served pointer.
// A locked grant moves to OWNx, where only x is served until x drops lock,
// drops req, or the burst counter reaches max_burst.

// Per-requester read-return tracker: delays "read issued" by STAGES cycles.
module ram_arbiter_lane #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic rvalid
);
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe = {vld_q, issue};

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  // Masked by reset so a return already in flight is hidden in the reset cycle.
  assign rvalid = vld_pipe[STAGES] & ~reset;
endmodule

module ram_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 4,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);
  localparam int NUM_LANES = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] BURST_MAX = 4'(max_burst);
  // With a burst of one, a lock can never extend ownership.
  localparam bit         LOCK_EN   = (max_burst > 1);

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_inc;
  logic       last, last_nxt;

  logic [NUM_LANES-1:0]                 req_v, lock_v, we_v, gnt_v, rvalid_v;
  logic [NUM_LANES-1:0][addr_width-1:0] addr_v;
  logic [NUM_LANES-1:0][data_width-1:0] wdata_v;

  logic gid;      // id selected this cycle (meaningful only with any_gnt)
  logic any_gnt;

  assign req_v   = {req1, req0};
  assign lock_v  = {lock1, lock0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  // Grant selection
  always_comb begin
    gnt_v = '0;
    gid   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          // Tie goes to the requester that was not served last.
          gid        = (&req_v) ? ~last : req_v[1];
          gnt_v[gid] = |req_v;
        end
        OWN0: begin
          gid      = 1'b0;
          gnt_v[0] = req_v[0];
        end
        OWN1: begin
          gid      = 1'b1;
          gnt_v[1] = req_v[1];
        end
        default: gnt_v = '0;
      endcase
    end
  end

  assign any_gnt = |gnt_v;
  assign cnt_inc = cnt + 4'd1;

  // Ownership / burst bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          last_nxt = gid;
          if (LOCK_EN && lock_v[gid]) begin
            state_nxt = gid ? OWN1 : OWN0;
            cnt_nxt   = 4'd1;
          end
        end
      end
      OWN0, OWN1: begin
        if (any_gnt) begin
          last_nxt = gid;
          if (!lock_v[gid] || cnt_inc == BURST_MAX) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
        end else begin
          // Owner went quiet: release without a grant.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // RAM port: granted requester drives everything, otherwise all zero.
  assign ram_write         = any_gnt & we_v[gid];
  assign ram_read_address  = any_gnt ? addr_v[gid]  : '0;
  assign ram_write_address = any_gnt ? addr_v[gid]  : '0;
  assign ram_din           = any_gnt ? wdata_v[gid] : '0;

  // Read returns
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ram_arbiter_lane #(.STAGES(1)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .issue  (gnt_v[i] & ~we_v[i]),
      .rvalid (rvalid_v[i])
    );
  end

  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (max_burst=4 and max_burst=1) share
// stimulus, each with its own RAM. A behavioural model per instance is
// checked every cycle; directed cycles pin the model with literal values.
module tb_ram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;

  logic        g0 [2], g1 [2], rv0 [2], rv1 [2], rw [2];
  logic [31:0] rd0 [2], rd1 [2], din [2], dout [2];
  logic [3:0]  ra [2], wa [2];
  logic [31:0] mem [2][16];

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.data_width(32), .addr_width(4), .max_burst(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(g0[0]), .gnt1(g1[0]), .rvalid0(rv0[0]), .rvalid1(rv1[0]),
    .rdata0(rd0[0]), .rdata1(rd1[0]),
    .ram_read_address(ra[0]), .ram_write_address(wa[0]), .ram_write(rw[0]),
    .ram_din(din[0]), .ram_dout(dout[0]));

  ram_arbiter #(.data_width(32), .addr_width(4), .max_burst(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(g0[1]), .gnt1(g1[1]), .rvalid0(rv0[1]), .rvalid1(rv1[1]),
    .rdata0(rd0[1]), .rdata1(rd1[1]),
    .ram_read_address(ra[1]), .ram_write_address(wa[1]), .ram_write(rw[1]),
    .ram_din(din[1]), .ram_dout(dout[1]));

  // RAMs: registered read, read-before-write on the same edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rw[i]) mem[i][wa[i]] <= din[i];
      dout[i] <= mem[i][ra[i]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          owner [2];   // -1: nobody holds the RAM
  int          burst [2];   // grants in current ownership
  int          last  [2];
  int          mb    [2];
  bit          pv    [2][2];
  logic [31:0] pd    [2];
  logic [31:0] mm    [2][16];

  task automatic model_step(input int i);
    int          g;
    bit          r [2], l [2], w [2];
    logic [3:0]  a [2];
    logic [31:0] d [2];
    string       t;
    t = $sformatf("mb%0d", mb[i]);
    r = '{req0, req1}; l = '{lock0, lock1}; w = '{we0, we1};
    a = '{addr0, addr1}; d = '{wdata0, wdata1};

    chk({t, " excl_gnt"}, 32'(g0[i] & g1[i]), 0);
    chk({t, " write_wo_gnt"}, 32'((!g0[i] && !g1[i]) && rw[i]), 0);

    if (reset) begin
      chk({t, " rst_gnt0"}, 32'(g0[i]), 0);
      chk({t, " rst_gnt1"}, 32'(g1[i]), 0);
      chk({t, " rst_write"}, 32'(rw[i]), 0);
      chk({t, " rst_rvalid0"}, 32'(rv0[i]), 0);
      chk({t, " rst_rvalid1"}, 32'(rv1[i]), 0);
      owner[i] = -1; burst[i] = 0; last[i] = 1;
      pv[i][0] = 0; pv[i][1] = 0;
      return;
    end

    g = -1;
    if (owner[i] < 0) begin
      if (r[0] && r[1]) g = 1 - last[i];
      else if (r[0])    g = 0;
      else if (r[1])    g = 1;
    end else if (r[owner[i]]) begin
      g = owner[i];
    end

    chk({t, " gnt0"}, 32'(g0[i]), 32'(g == 0));
    chk({t, " gnt1"}, 32'(g1[i]), 32'(g == 1));
    chk({t, " ram_write"}, 32'(rw[i]), (g >= 0) ? 32'(w[g]) : 0);
    chk({t, " raddr"}, 32'(ra[i]), (g >= 0) ? 32'(a[g]) : 0);
    chk({t, " waddr"}, 32'(wa[i]), (g >= 0) ? 32'(a[g]) : 0);
    chk({t, " din"}, din[i], (g >= 0) ? d[g] : 0);
    chk({t, " rvalid0"}, 32'(rv0[i]), 32'(pv[i][0]));
    chk({t, " rvalid1"}, 32'(rv1[i]), 32'(pv[i][1]));
    if (pv[i][0]) chk({t, " rdata0"}, rd0[i], pd[i]);
    if (pv[i][1]) chk({t, " rdata1"}, rd1[i], pd[i]);

    pv[i][0] = 0; pv[i][1] = 0;
    if (g >= 0) begin
      if (!w[g]) begin pv[i][g] = 1; pd[i] = mm[i][a[g]]; end
      else mm[i][a[g]] = d[g];
      last[i] = g;
      if (owner[i] < 0) begin
        if (l[g] && mb[i] > 1) begin owner[i] = g; burst[i] = 1; end
      end else begin
        burst[i]++;
        if (!l[g] || burst[i] == mb[i]) begin owner[i] = -1; burst[i] = 0; end
      end
    end else if (owner[i] >= 0) begin
      owner[i] = -1; burst[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    mb[0] = 4; mb[1] = 1;
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; burst[i] = 0; last[i] = 1; pv[i][0] = 0; pv[i][1] = 0; pd[i] = 0;
      for (int k = 0; k < 16; k++) begin
        mem[i][k] <= 32'hC0DE_0000 | 32'(k);
        mm[i][k]  =  32'hC0DE_0000 | 32'(k);
      end
    end
    reset = 1; req0 = 1; req1 = 1; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = 4'd3; addr1 = 4'd5; wdata0 = 0; wdata1 = 0;

    // C0: reset held with both requesting
    repeat (2) tick();
    @(negedge clk);
    chk("c0 gnt0", 32'(g0[0]), 0); chk("c0 gnt1", 32'(g1[0]), 0);
    chk("c0 rvalid0", 32'(rv0[0]), 0); chk("c0 ram_write", 32'(rw[0]), 0);

    // C1..C4: alternation, requester 0 wins the first tie
    tick(); reset = 0; @(negedge clk);
    chk("c1 gnt0", 32'(g0[0]), 1); chk("c1 gnt1", 32'(g1[0]), 0);
    chk("c1 raddr", 32'(ra[0]), 3); chk("c1 mb1 gnt0", 32'(g0[1]), 1);
    tick(); @(negedge clk);
    chk("c2 gnt1", 32'(g1[0]), 1); chk("c2 rvalid0", 32'(rv0[0]), 1);
    chk("c2 rdata0", rd0[0], 32'hC0DE_0003);
    tick(); @(negedge clk);
    chk("c3 gnt0", 32'(g0[0]), 1); chk("c3 rvalid1", 32'(rv1[0]), 1);
    chk("c3 rdata1", rd1[0], 32'hC0DE_0005);
    tick(); @(negedge clk);
    chk("c4 gnt1", 32'(g1[0]), 1);

    // C5..C7: write then read back
    tick(); req1 = 0; we0 = 1; addr0 = 4'd2; wdata0 = 32'hA5A5_A5A5; @(negedge clk);
    chk("c5 gnt0", 32'(g0[0]), 1); chk("c5 ram_write", 32'(rw[0]), 1);
    chk("c5 din", din[0], 32'hA5A5_A5A5); chk("c5 waddr", 32'(wa[0]), 2);
    chk("c5 rvalid1", 32'(rv1[0]), 1);
    tick(); we0 = 0; @(negedge clk);
    chk("c6 gnt0", 32'(g0[0]), 1); chk("c6 ram_write", 32'(rw[0]), 0);
    chk("c6 rvalid0_after_write", 32'(rv0[0]), 0);
    tick(); req0 = 0; @(negedge clk);
    chk("c7 rvalid0", 32'(rv0[0]), 1); chk("c7 rdata0", rd0[0], 32'hA5A5_A5A5);
    chk("c7 gnt0", 32'(g0[0]), 0); chk("c7 raddr_idle", 32'(ra[0]), 0);

    // C8: serve 1 so that 0 wins the next tie
    tick(); req1 = 1; addr0 = 4'd3; @(negedge clk);
    chk("c8 gnt1", 32'(g1[0]), 1);

    // C9..C13: locked burst of 4 for requester 0, then 1
    tick(); req0 = 1; lock0 = 1; @(negedge clk);
    chk("c9 gnt0", 32'(g0[0]), 1); chk("c9 gnt1", 32'(g1[0]), 0);
    tick(); @(negedge clk);
    chk("c10 gnt0", 32'(g0[0]), 1); chk("c10 gnt1", 32'(g1[0]), 0);
    chk("c10 mb1 gnt1", 32'(g1[1]), 1);
    tick(); @(negedge clk);
    chk("c11 gnt0", 32'(g0[0]), 1); chk("c11 gnt1", 32'(g1[0]), 0);
    tick(); @(negedge clk);
    chk("c12 gnt0", 32'(g0[0]), 1); chk("c12 gnt1", 32'(g1[0]), 0);
    tick(); @(negedge clk);
    chk("c13 gnt1", 32'(g1[0]), 1); chk("c13 gnt0", 32'(g0[0]), 0);

    // C14..C16: owner drops req for a cycle
    tick(); req1 = 0; @(negedge clk);
    chk("c14 gnt0", 32'(g0[0]), 1);
    tick(); req0 = 0; req1 = 1; @(negedge clk);
    chk("c15 gnt0", 32'(g0[0]), 0); chk("c15 gnt1", 32'(g1[0]), 0);
    tick(); req0 = 1; lock0 = 0; @(negedge clk);
    chk("c16 gnt1", 32'(g1[0]), 1);

    // C17..C19: reset during an OWN1 burst with a read in flight
    tick(); req0 = 0; req1 = 1; lock1 = 1; we1 = 0; addr1 = 4'd5; @(negedge clk);
    chk("c17 gnt1", 32'(g1[0]), 1);
    tick(); reset = 1; @(negedge clk);
    chk("c18 gnt1", 32'(g1[0]), 0); chk("c18 rvalid1", 32'(rv1[0]), 0);
    tick(); reset = 0; req0 = 1; req1 = 1; lock1 = 0; @(negedge clk);
    chk("c19 gnt0", 32'(g0[0]), 1); chk("c19 rvalid1", 32'(rv1[0]), 0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset  = ($urandom_range(99) == 0);
      req0   = 1'($urandom_range(3) != 0);
      req1   = 1'($urandom_range(3) != 0);
      lock0  = 1'($urandom);
      lock1  = 1'($urandom);
      we0    = ($urandom_range(2) == 0);
      we1    = ($urandom_range(2) == 0);
      addr0  = 4'($urandom);
      addr1  = 4'($urandom);
      wdata0 = $urandom;
      wdata1 = $urandom;
    end
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
